// File: rtl/seq_gen_defs.sv
// Package: seq_gen_defs
// Shared definitions for the sequence generator:
//   - MODE_* encodings of the 3-bit MODE input (codes 5-7 are reserved)
//   - one origin function per mode, plus a dispatcher that picks the origin
//     for a given MODE code at a given state width
//   - is_step_mode(): true for the modes that actually advance the state
// The origin functions return MAX_WIDTH bits, so any WIDTH up to 64 is
// supported. Callers cast the result down to their own width.
package seq_gen_defs;

  localparam int MAX_WIDTH = 64;

  localparam logic [2:0] MODE_UP      = 3'd0;
  localparam logic [2:0] MODE_DOWN    = 3'd1;
  localparam logic [2:0] MODE_GRAY    = 3'd2;
  localparam logic [2:0] MODE_JOHNSON = 3'd3;
  localparam logic [2:0] MODE_LFSR    = 3'd4;

  function automatic logic [MAX_WIDTH-1:0] origin_up();
    return '0;
  endfunction

  // All-ones at the requested width.
  function automatic logic [MAX_WIDTH-1:0] origin_down(input int width);
    return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] origin_gray();
    return '0;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] origin_johnson();
    return '0;
  endfunction

  // An LFSR cannot sit at zero, so its origin is the single-bit value 0..01.
  function automatic logic [MAX_WIDTH-1:0] origin_lfsr();
    return MAX_WIDTH'(1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] mode_origin(input logic [2:0] mode,
                                                       input int         width);
    case (mode)
      MODE_DOWN:    return origin_down(width);
      MODE_GRAY:    return origin_gray();
      MODE_JOHNSON: return origin_johnson();
      MODE_LFSR:    return origin_lfsr();
      default:      return origin_up();
    endcase
  endfunction

  function automatic logic is_step_mode(input logic [2:0] mode);
    return mode <= MODE_LFSR;
  endfunction

endpackage

// File: rtl/seq_next_logic.sv
// Module: seq_next_logic
// Pure combinational next-state logic of the sequence generator.
// Ports:
//   s         in  [WIDTH-1:0]  current state
//   mode      in  [2:0]        sequence select (5-7 reserved: n = s)
//   n         out [WIDTH-1:0]  next state under the selected mode
//   origin    out [WIDTH-1:0]  origin value of the selected mode
//   step_en   out              mode is a stepping mode (not reserved)
//   corrected out              n is a recovery jump (invalid Johnson code or
//                              LFSR lock-up), not a regular sequence step
module seq_next_logic
  import seq_gen_defs::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 4'b1100
) (
  input  logic [WIDTH-1:0] s,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] origin,
  output logic             step_en,
  output logic             corrected
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Legal Johnson codes look like 0..01..1 or 1..10..0: at most one place
  // where neighbouring bits differ. Clearing the lowest set bit of the
  // boundary mask leaves zero exactly when there is at most one boundary.
  function automatic logic johnson_valid(input logic [WIDTH-1:0] v);
    logic [WIDTH-2:0] edges;
    edges = v[WIDTH-1:1] ^ v[WIDTH-2:0];
    return (edges & (edges - 1'b1)) == '0;
  endfunction

  assign origin  = WIDTH'(mode_origin(mode, WIDTH));
  assign step_en = is_step_mode(mode);

  // NOTE: every output gets a default before the case so that no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    n         = s;
    corrected = 1'b0;
    case (mode)
      MODE_UP:   n = s + ONE;
      MODE_DOWN: n = s - ONE;
      MODE_GRAY: n = bin2gray(gray2bin(s) + ONE);
      MODE_JOHNSON: begin
        if (johnson_valid(s)) begin
          n = {s[WIDTH-2:0], ~s[WIDTH-1]};
        end else begin
          n         = '0;
          corrected = 1'b1;
        end
      end
      MODE_LFSR: begin
        if (s == '0) begin
          n         = ONE;
          corrected = 1'b1;
        end else begin
          n = {s[WIDTH-2:0], ^(s & LFSR_TAPS)};
        end
      end
      default: n = s;
    endcase
  end

endmodule

// File: rtl/seq_generator.sv
// Module: seq_generator
// Mode-selectable sequence generator: up, down, Gray, Johnson or LFSR.
// Ports:
//   CLK       in                rising-edge clock
//   RST       in                asynchronous active-low reset
//   CE        in                step enable (0 holds)
//   LOAD      in                synchronous load, wins over CE
//   LOAD_VAL  in  [WIDTH-1:0]   value written on LOAD
//   MODE      in  [2:0]         sequence select (5-7 reserved, hold)
//   OUT       out [WIDTH-1:0]   current state
//   OUT_NEXT  out [WIDTH-1:0]   combinational next state for MODE, ignores CE
//   WRAP      out               one-cycle pulse: a regular step landed on the origin
//   PERIOD    out [WIDTH:0]     step count of the last completed period
module seq_generator
  import seq_gen_defs::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] INIT      = '0,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 4'b1100
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic [2:0]       MODE,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_NEXT,
  output logic             WRAP,
  output logic [WIDTH:0]   PERIOD
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   period_q, period_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] next_state;
  logic [WIDTH-1:0] origin;
  logic             step_en;
  logic             corrected;
  logic [WIDTH:0]   cnt_inc;

  seq_next_logic #(
    .WIDTH     (WIDTH),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_next (
    .s         (state_q),
    .mode      (MODE),
    .n         (next_state),
    .origin    (origin),
    .step_en   (step_en),
    .corrected (corrected)
  );

  // Step counter saturates instead of rolling over, so a very long run
  // reports a pinned maximum rather than a misleading small period.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + (WIDTH + 1)'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    if (LOAD) begin
      state_d = LOAD_VAL;
      cnt_d   = '0;
    end else if (CE && step_en) begin
      state_d = next_state;
      if (corrected) begin
        // A recovery jump lands on the origin without completing a period:
        // restart the measurement but do not report a wrap.
        cnt_d = '0;
      end else if (next_state == origin) begin
        wrap_d   = 1'b1;
        period_d = cnt_inc;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
    end
  end

  assign OUT      = state_q;
  assign OUT_NEXT = next_state;
  assign WRAP     = wrap_q;
  assign PERIOD   = period_q;

endmodule

// File: tb/tb_seq_generator.sv
// Testbench for seq_generator (WIDTH=4, INIT=0, taps x^4+x^3+1).
// Directed scenarios with constant expectations, then a randomized run
// checked against a behavioural model of the sequences.
module tb_seq_generator;

  localparam int             W     = 4;
  localparam int             MASK  = (1 << W) - 1;
  localparam int             CMAX  = (1 << (W + 1)) - 1;
  localparam logic [W-1:0]   TAPS  = 4'b1100;
  localparam logic [W-1:0]   INITV = 4'b0000;

  logic         CLK = 1'b0;
  logic         RST;
  logic         CE;
  logic         LOAD;
  logic [W-1:0] LOAD_VAL;
  logic [2:0]   MODE;
  logic [W-1:0] OUT;
  logic [W-1:0] OUT_NEXT;
  logic         WRAP;
  logic [W:0]   PERIOD;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int m_state, m_cnt, m_period;
  bit m_wrap;
  int johnson_tbl[8] = '{0, 1, 3, 7, 15, 14, 12, 8};

  seq_generator #(.WIDTH(W), .INIT(INITV), .LFSR_TAPS(TAPS)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .MODE(MODE), .OUT(OUT), .OUT_NEXT(OUT_NEXT), .WRAP(WRAP), .PERIOD(PERIOD)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required earlier finish");
    $fatal(1, "watchdog");
  end

  function automatic int johnson_index(int s);
    for (int k = 0; k < 8; k++) if (johnson_tbl[k] == s) return k;
    return -1;
  endfunction

  function automatic int ref_next(int s, int mode);
    int j;
    case (mode)
      0: return (s + 1) & MASK;
      1: return (s + MASK) & MASK;
      2: begin
        for (int i = 0; i <= MASK; i++) begin
          if ((i ^ (i >> 1)) == s) begin
            j = (i + 1) & MASK;
            return j ^ (j >> 1);
          end
        end
        return s;
      end
      3: begin
        j = johnson_index(s);
        return (j < 0) ? 0 : johnson_tbl[(j + 1) % 8];
      end
      4: begin
        if (s == 0) return 1;
        return ((s << 1) & MASK) | ($countones(s & int'(TAPS)) % 2);
      end
      default: return s;
    endcase
  endfunction

  function automatic bit ref_corrected(int s, int mode);
    if (mode == 3) return johnson_index(s) < 0;
    if (mode == 4) return s == 0;
    return 1'b0;
  endfunction

  function automatic int ref_origin(int mode);
    if (mode == 1) return MASK;
    if (mode == 4) return 1;
    return 0;
  endfunction

  task automatic reset_model();
    m_state = int'(INITV); m_cnt = 0; m_period = 0; m_wrap = 0;
  endtask

  // One clock edge: advance the model from the currently driven inputs,
  // then wait for the edge and settle.
  task automatic tick();
    int md, nx;
    md = int'(MODE);
    if (LOAD) begin
      m_state = int'(LOAD_VAL); m_cnt = 0; m_wrap = 0;
    end else if (CE && md < 5) begin
      nx = ref_next(m_state, md);
      m_wrap = 0;
      if (ref_corrected(m_state, md)) begin
        m_cnt = 0;
      end else if (nx == ref_origin(md)) begin
        m_period = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
        m_cnt = 0; m_wrap = 1;
      end else begin
        m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      end
      m_state = nx;
    end else begin
      m_wrap = 0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; CE = 1'b0; LOAD = 1'b0; LOAD_VAL = '0; MODE = 3'd0;
    reset_model();
    #12;
    checks++; if (OUT !== INITV) begin errors++; $display("FAIL reset_out: got %0h expected %0h", OUT, INITV); end
    checks++; if (WRAP !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0b expected 0", WRAP); end
    checks++; if (PERIOD !== '0) begin errors++; $display("FAIL reset_period: got %0d expected 0", PERIOD); end
    @(negedge CLK); RST = 1'b1;
    tick();
  endtask

  task automatic test_up();
    int e;
    MODE = 3'd0; CE = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      e = (i + 1) % 16;
      checks++; if (OUT !== W'(e)) begin errors++; $display("FAIL up_out step %0d: got %0h expected %0h", i, OUT, e); end
      checks++; if (WRAP !== (i == 15)) begin errors++; $display("FAIL up_wrap step %0d: got %0b expected %0b", i, WRAP, i == 15); end
    end
    checks++; if (PERIOD !== 5'd16) begin errors++; $display("FAIL up_period: got %0d expected 16", PERIOD); end
  endtask

  task automatic test_johnson();
    int exp_seq[8] = '{1, 3, 7, 15, 14, 12, 8, 0};
    MODE = 3'd3; CE = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (OUT !== W'(exp_seq[k])) begin errors++; $display("FAIL johnson_out step %0d: got %0h expected %0h", k, OUT, exp_seq[k]); end
      checks++; if (WRAP !== (k == 7)) begin errors++; $display("FAIL johnson_wrap step %0d: got %0b expected %0b", k, WRAP, k == 7); end
    end
    checks++; if (PERIOD !== 5'd8) begin errors++; $display("FAIL johnson_period: got %0d expected 8", PERIOD); end
    LOAD = 1'b1; LOAD_VAL = 4'b0101; CE = 1'b0;
    tick();
    LOAD = 1'b0; CE = 1'b1;
    tick();
    checks++; if (OUT !== 4'b0000) begin errors++; $display("FAIL johnson_fix_out: got %0h expected 0", OUT); end
    checks++; if (WRAP !== 1'b0) begin errors++; $display("FAIL johnson_fix_wrap: got %0b expected 0", WRAP); end
    checks++; if (PERIOD !== 5'd8) begin errors++; $display("FAIL johnson_fix_period: got %0d expected 8", PERIOD); end
  endtask

  task automatic test_lfsr();
    int exp_seq[4] = '{2, 4, 9, 3};
    bit seen;
    MODE = 3'd4; LOAD = 1'b1; LOAD_VAL = 4'b0000; CE = 1'b0;
    tick();
    LOAD = 1'b0; CE = 1'b1;
    tick();
    checks++; if (OUT !== 4'b0001) begin errors++; $display("FAIL lfsr_escape_out: got %0h expected 1", OUT); end
    checks++; if (WRAP !== 1'b0) begin errors++; $display("FAIL lfsr_escape_wrap: got %0b expected 0", WRAP); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (OUT !== W'(exp_seq[k])) begin errors++; $display("FAIL lfsr_out step %0d: got %0h expected %0h", k, OUT, exp_seq[k]); end
    end
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      seen = WRAP;
    end
    checks++; if (!seen) begin errors++; $display("FAIL lfsr_wrap_timeout: got no WRAP in 40 steps, required one"); end
    checks++; if (OUT !== 4'b0001) begin errors++; $display("FAIL lfsr_wrap_out: got %0h expected 1", OUT); end
    checks++; if (PERIOD !== 5'd15) begin errors++; $display("FAIL lfsr_period: got %0d expected 15", PERIOD); end
  endtask

  task automatic test_gray();
    int j, e;
    MODE = 3'd2; LOAD = 1'b1; LOAD_VAL = 4'b0000; CE = 1'b0;
    tick();
    LOAD = 1'b0; CE = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      j = (i + 1) % 16;
      e = j ^ (j >> 1);
      checks++; if (OUT !== W'(e)) begin errors++; $display("FAIL gray_out step %0d: got %0h expected %0h", i, OUT, e); end
      checks++; if (WRAP !== (i == 15)) begin errors++; $display("FAIL gray_wrap step %0d: got %0b expected %0b", i, WRAP, i == 15); end
    end
    checks++; if (PERIOD !== 5'd16) begin errors++; $display("FAIL gray_period: got %0d expected 16", PERIOD); end
  endtask

  task automatic test_down_load();
    MODE = 3'd1; LOAD = 1'b1; CE = 1'b1; LOAD_VAL = 4'b1010;
    tick();
    checks++; if (OUT !== 4'b1010) begin errors++; $display("FAIL down_load_out: got %0h expected a", OUT); end
    checks++; if (WRAP !== 1'b0) begin errors++; $display("FAIL down_load_wrap: got %0b expected 0", WRAP); end
    LOAD = 1'b0;
    tick();
    checks++; if (OUT !== 4'b1001) begin errors++; $display("FAIL down_step_out: got %0h expected 9", OUT); end
    CE = 1'b0;
    #1;
    checks++; if (OUT_NEXT !== 4'b1000) begin errors++; $display("FAIL down_out_next: got %0h expected 8", OUT_NEXT); end
    tick();
    checks++; if (OUT !== 4'b1001) begin errors++; $display("FAIL down_hold_out: got %0h expected 9", OUT); end
  endtask

  task automatic test_async_reset_reserved();
    MODE = 3'd0; LOAD = 1'b1; LOAD_VAL = 4'b1111; CE = 1'b0;
    tick();
    LOAD = 1'b0; CE = 1'b1;
    tick();
    checks++; if (WRAP !== 1'b1 || PERIOD !== 5'd1) begin errors++; $display("FAIL prereset_state: got wrap %0b period %0d expected wrap 1 period 1", WRAP, PERIOD); end
    #3 RST = 1'b0;
    #1;
    reset_model();
    checks++; if (OUT !== INITV) begin errors++; $display("FAIL async_reset_out: got %0h expected %0h", OUT, INITV); end
    checks++; if (WRAP !== 1'b0) begin errors++; $display("FAIL async_reset_wrap: got %0b expected 0", WRAP); end
    checks++; if (PERIOD !== '0) begin errors++; $display("FAIL async_reset_period: got %0d expected 0", PERIOD); end
    #2 RST = 1'b1;
    @(posedge CLK); #1;
    LOAD = 1'b1; LOAD_VAL = 4'b0111; CE = 1'b0;
    tick();
    LOAD = 1'b0; MODE = 3'd6; CE = 1'b1;
    #1;
    checks++; if (OUT_NEXT !== 4'b0111) begin errors++; $display("FAIL reserved_out_next: got %0h expected 7", OUT_NEXT); end
    tick();
    checks++; if (OUT !== 4'b0111) begin errors++; $display("FAIL reserved_hold_out: got %0h expected 7", OUT); end
    checks++; if (WRAP !== 1'b0) begin errors++; $display("FAIL reserved_wrap: got %0b expected 0", WRAP); end
  endtask

  task automatic test_random();
    int md;
    for (int c = 0; c < 600; c++) begin
      md       = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7);
      MODE     = 3'(md);
      LOAD     = ($urandom_range(0, 15) == 0);
      CE       = ($urandom_range(0, 3) != 0);
      LOAD_VAL = W'($urandom_range(0, MASK));
      #1;
      checks++; if (OUT_NEXT !== W'(ref_next(m_state, md))) begin errors++; $display("FAIL rand_out_next cycle %0d: got %0h expected %0h", c, OUT_NEXT, ref_next(m_state, md)); end
      tick();
      checks++; if (OUT !== W'(m_state)) begin errors++; $display("FAIL rand_out cycle %0d: got %0h expected %0h", c, OUT, m_state); end
      checks++; if (WRAP !== m_wrap) begin errors++; $display("FAIL rand_wrap cycle %0d: got %0b expected %0b", c, WRAP, m_wrap); end
      checks++; if (PERIOD !== (W+1)'(m_period)) begin errors++; $display("FAIL rand_period cycle %0d: got %0d expected %0d", c, PERIOD, m_period); end
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_johnson();
    test_lfsr();
    test_gray();
    test_down_load();
    test_async_reset_reserved();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
